sram_1r1w_arbiter: RTL and testbench
====================================

SRAM_1R1W_ARBITER -- requirements
Module: sram_1r1w_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, meaning SRAM data width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, meaning SRAM address width (depth 2^ADDR_SIZE).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port init_req  input  1  one-cycle pulse requesting a zero-fill of the whole SRAM.
REQ-006 SHALL have port busy  output  1  high while in INIT.
REQ-007 SHALL have port rd_req_valid  input  2  per-requester read request.
REQ-008 SHALL have port rd_req_addr  input  2*ADDR_SIZE  read address; requester i at bits [i*ADDR_SIZE +: ADDR_SIZE].
REQ-009 SHALL have port rd_req_ready  output  2  read grant, at most one bit high.
REQ-010 SHALL have port rd_rsp_valid  output  2  one-hot read response strobe.
REQ-011 SHALL have port rd_rsp_data  output  WORD_SIZE  read response data.
REQ-012 SHALL have port wr_req_valid  input  2  per-requester write request.
REQ-013 SHALL have port wr_req_addr  input  2*ADDR_SIZE  write address, packed as in REQ-008.
REQ-014 SHALL have port wr_req_data  input  2*WORD_SIZE  write data, packed per requester.
REQ-015 SHALL have port wr_req_ready  output  2  write grant, at most one bit high.
REQ-016 SHALL have ports mem_we/mem_waddr/mem_wdata (outputs 1/ADDR_SIZE/WORD_SIZE) and mem_re/mem_raddr (outputs 1/ADDR_SIZE), driving the SRAM write and read ports.
REQ-017 SHALL have port mem_rdata  input  WORD_SIZE  SRAM read data, valid the cycle after mem_re.

Function
REQ-018 SHALL implement states INIT and RUN; state is INIT after reset.
REQ-019 In INIT, SHALL assert mem_we with mem_waddr equal to an ADDR_SIZE-bit counter and mem_wdata equal to 0; counter increments each cycle.
REQ-020 After the cycle writing address 2^ADDR_SIZE-1, SHALL enter RUN and clear the counter; INIT lasts exactly 2^ADDR_SIZE cycles.
REQ-021 In INIT, SHALL hold rd_req_ready, wr_req_ready and mem_re at 0; init_req is ignored.
REQ-022 In RUN, init_req=1 SHALL move the state to INIT on the next edge; any grant in that same cycle still completes.
REQ-023 In RUN, read and write channels SHALL be arbitrated independently, at most one grant per channel per cycle.
REQ-024 Each channel SHALL use a round-robin pointer: if both requesters are valid, grant the pointer requester; if only one is valid, grant it; after a grant, the pointer moves to the other requester.
REQ-025 Grants (ready) SHALL be combinational from valid and state; a transfer occurs when valid and ready are both high.
REQ-026 On read grant i, SHALL drive mem_re=1 and mem_raddr=rd_req_addr[i]; rd_rsp_valid[i] SHALL be a register set 1 on the following cycle for exactly one cycle.
REQ-027 rd_rsp_data SHALL equal mem_rdata (pass-through); it is meaningful only while rd_rsp_valid is nonzero.
REQ-028 On write grant i, SHALL drive mem_we=1 with the address and data of requester i; mem_we=0 otherwise in RUN.
REQ-029 A read and a write granted in the same cycle to the same address SHALL return the newly written data (write-first).
REQ-030 An ungranted requester SHALL keep its request pending; the arbiter SHALL never drop or duplicate a request.

Reset
REQ-031 On rst high: state=INIT, counter=0, rd_rsp_valid=0, both round-robin pointers=requester 0, busy=1; all SRAM strobes low while rst is high.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL restart the zero-fill from address 0 after release.

Verification (ADDR_SIZE=4, WORD_SIZE=8)
REQ-033 Release reset -> busy=1 for 16 cycles, mem_we=1 with waddr 0..15 and wdata 0x00, then busy=0 and grants become possible.
REQ-034 Both rd_req_valid held high, addresses 3 and 5 -> grants alternate 0,1,0,1 starting at 0; rd_rsp_valid = 01,10,01,... each one cycle after its grant.
REQ-035 Requester 0 writes addr 7 data 0xA5 while requester 1 reads addr 7 in the same cycle -> both granted; next cycle rd_rsp_valid=10 and rd_rsp_data=0xA5.
REQ-036 Both wr_req_valid high with data 0x11 and 0x22 to addr 2 -> requester 0 granted first, requester 1 next cycle; subsequent read of addr 2 returns 0x22.
REQ-037 init_req pulsed in the same cycle as a read grant -> response delivered next cycle, then 16 INIT cycles; reads of any address afterwards return 0x00.
REQ-038 rst pulsed when the INIT counter reaches 9 -> after release, zero-fill restarts at address 0 and runs the full 16 cycles.

Source files
------------

// File: rtl/sram_1r1w_arbiter_if.sv
// Request/response bundle between two read/write requesters, the arbiter,
// and the attached 1R1W SRAM macro.
interface sram_1r1w_arbiter_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 4
);
  logic                   init_req;
  logic                   busy;
  logic [1:0]             rd_req_valid;
  logic [2*ADDR_SIZE-1:0] rd_req_addr;
  logic [1:0]             rd_req_ready;
  logic [1:0]             rd_rsp_valid;
  logic [WORD_SIZE-1:0]   rd_rsp_data;
  logic [1:0]             wr_req_valid;
  logic [2*ADDR_SIZE-1:0] wr_req_addr;
  logic [2*WORD_SIZE-1:0] wr_req_data;
  logic [1:0]             wr_req_ready;
  logic                   mem_we;
  logic [ADDR_SIZE-1:0]   mem_waddr;
  logic [WORD_SIZE-1:0]   mem_wdata;
  logic                   mem_re;
  logic [ADDR_SIZE-1:0]   mem_raddr;
  logic [WORD_SIZE-1:0]   mem_rdata;

  // Arbiter side.
  modport slave (
    input  init_req, rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr,
           wr_req_data, mem_rdata,
    output busy, rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready,
           mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
  );

  // Requester + SRAM side.
  modport master (
    output init_req, rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr,
           wr_req_data, mem_rdata,
    input  busy, rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready,
           mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
  );
endinterface

// File: rtl/sram_1r1w_arbiter.sv
// Two-requester arbiter in front of a 1R1W SRAM. After reset (or an
// init_req) the whole array is zero-filled, then read and write channels are
// round-robin arbitrated independently. Read data is passed straight through
// from the SRAM, so the macro itself must be write-first for same-address
// read/write collisions.
module sram_1r1w_arbiter #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_1r1w_arbiter_if.slave    bus
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic [1:0]           rsp_q, rsp_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           rd_gnt, wr_gnt;
  logic                 run;

  // Round-robin pick: contention goes to the pointer, a lone request wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] vld, input logic ptr);
    case (vld)
      2'b11:   rr_pick = ptr ? 2'b10 : 2'b01;
      default: rr_pick = vld;
    endcase
  endfunction

  assign run = (state_q == RUN);

  // Combinational grants; nothing is granted while filling.
  always_comb begin
    rd_gnt = 2'b00;
    wr_gnt = 2'b00;
    if (run) begin
      rd_gnt = rr_pick(bus.rd_req_valid, rd_ptr_q);
      wr_gnt = rr_pick(bus.wr_req_valid, wr_ptr_q);
    end
  end

  // Next-state: fill counter, INIT/RUN transitions, pointers, read strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rsp_d    = rd_gnt;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = '0;
        // Grants issued this cycle still complete; the fill starts next edge.
        if (bus.init_req) state_d = INIT;
      end
    endcase
    if (rd_gnt[0]) rd_ptr_d = 1'b1;
    if (rd_gnt[1]) rd_ptr_d = 1'b0;
    if (wr_gnt[0]) wr_ptr_d = 1'b1;
    if (wr_gnt[1]) wr_ptr_d = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rsp_q    <= 2'b00;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rsp_q    <= rsp_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // SRAM port muxing; strobes are forced low while reset is held.
  always_comb begin
    bus.mem_re    = !rst && (|rd_gnt);
    bus.mem_raddr = rd_gnt[1] ? bus.rd_req_addr[ADDR_SIZE +: ADDR_SIZE]
                              : bus.rd_req_addr[0 +: ADDR_SIZE];
    bus.mem_we    = !rst && (!run || (|wr_gnt));
    bus.mem_waddr = cnt_q;
    bus.mem_wdata = '0;
    if (run) begin
      bus.mem_waddr = wr_gnt[1] ? bus.wr_req_addr[ADDR_SIZE +: ADDR_SIZE]
                                : bus.wr_req_addr[0 +: ADDR_SIZE];
      bus.mem_wdata = wr_gnt[1] ? bus.wr_req_data[WORD_SIZE +: WORD_SIZE]
                                : bus.wr_req_data[0 +: WORD_SIZE];
    end
  end

  assign bus.busy         = !run;
  assign bus.rd_req_ready = rd_gnt;
  assign bus.wr_req_ready = wr_gnt;
  assign bus.rd_rsp_valid = rsp_q;
  assign bus.rd_rsp_data  = bus.mem_rdata;

endmodule

// File: tb/tb_sram_1r1w_arbiter.sv
// Directed bench: write-first SRAM model plus a linear sequence of steps.
// Inputs are driven just after the falling edge, outputs checked 1 ns later.
module tb_sram_1r1w_arbiter;
  localparam int WS = 8;
  localparam int AS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  sram_1r1w_arbiter_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus_if ();

  sram_1r1w_arbiter #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // Write-first 1R1W SRAM model, read data valid the cycle after mem_re.
  logic [WS-1:0] sram [1<<AS];
  logic [WS-1:0] sram_rdata;
  always @(posedge clk) begin
    if (bus_if.mem_we) sram[bus_if.mem_waddr] <= bus_if.mem_wdata;
    if (bus_if.mem_re)
      sram_rdata <= (bus_if.mem_we && bus_if.mem_waddr == bus_if.mem_raddr)
                    ? bus_if.mem_wdata : sram[bus_if.mem_raddr];
  end
  assign bus_if.mem_rdata = sram_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Checks one zero-fill cycle at fill address a.
  task automatic chk_fill(input string tag, input int a);
    chk({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
    chk({tag, "_we"},   32'(bus_if.mem_we), 32'd1);
    chk({tag, "_wa"},   32'(bus_if.mem_waddr), 32'(a));
    chk({tag, "_wd"},   32'(bus_if.mem_wdata), 32'd0);
  endtask

  initial begin
    bus_if.init_req     = 1'b0;
    bus_if.rd_req_valid = 2'b00;
    bus_if.rd_req_addr  = '0;
    bus_if.wr_req_valid = 2'b00;
    bus_if.wr_req_addr  = '0;
    bus_if.wr_req_data  = '0;

    // Reset state.
    step(); #1;
    chk("rst_busy", 32'(bus_if.busy), 32'd1);
    chk("rst_we",   32'(bus_if.mem_we), 32'd0);
    chk("rst_re",   32'(bus_if.mem_re), 32'd0);
    chk("rst_rsp",  32'(bus_if.rd_rsp_valid), 32'd0);
    rst = 1'b0;

    // Zero-fill after release; requests and init_req are held off/ignored.
    bus_if.rd_req_addr = {4'd5, 4'd3};
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      bus_if.rd_req_valid = 2'b11;
      bus_if.init_req     = (i == 5);
      #1;
      chk_fill("init0", i);
      chk("init0_rdy", 32'(bus_if.rd_req_ready), 32'd0);
      chk("init0_re",  32'(bus_if.mem_re), 32'd0);
    end

    // Both readers contend: grants alternate starting at requester 0.
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      chk("rr_busy", 32'(bus_if.busy), 32'd0);
      chk("rr_rdy",  32'(bus_if.rd_req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_re",   32'(bus_if.mem_re), 32'd1);
      chk("rr_ra",   32'(bus_if.mem_raddr), (k % 2 == 0) ? 32'd3 : 32'd5);
      chk("rr_rsp",  32'(bus_if.rd_rsp_valid), (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'h1 : 32'h2));
      if (k > 0) chk("rr_data", 32'(bus_if.rd_rsp_data), 32'h00);
    end
    step(); bus_if.rd_req_valid = 2'b00; #1;
    chk("rr_rsp_last", 32'(bus_if.rd_rsp_valid), 32'h2);
    chk("rr_re_idle",  32'(bus_if.mem_re), 32'd0);

    // Same-cycle write (req 0) and read (req 1) of address 7.
    step();
    bus_if.wr_req_valid = 2'b01;
    bus_if.wr_req_addr  = {4'd0, 4'd7};
    bus_if.wr_req_data  = {8'h00, 8'hA5};
    bus_if.rd_req_valid = 2'b10;
    bus_if.rd_req_addr  = {4'd7, 4'd0};
    #1;
    chk("wf_wrdy", 32'(bus_if.wr_req_ready), 32'h1);
    chk("wf_rrdy", 32'(bus_if.rd_req_ready), 32'h2);
    chk("wf_we",   32'(bus_if.mem_we), 32'd1);
    chk("wf_wa",   32'(bus_if.mem_waddr), 32'd7);
    chk("wf_wd",   32'(bus_if.mem_wdata), 32'hA5);
    chk("wf_ra",   32'(bus_if.mem_raddr), 32'd7);
    step();
    bus_if.wr_req_valid = 2'b00;
    bus_if.rd_req_valid = 2'b00;
    #1;
    chk("wf_rsp",  32'(bus_if.rd_rsp_valid), 32'h2);
    chk("wf_data", 32'(bus_if.rd_rsp_data), 32'hA5);
    chk("wf_we0",  32'(bus_if.mem_we), 32'd0);

    // Lone write from req 1 (addr 9 = 0x3C) brings the write pointer back to 0.
    step();
    bus_if.wr_req_valid = 2'b10;
    bus_if.wr_req_addr  = {4'd9, 4'd0};
    bus_if.wr_req_data  = {8'h3C, 8'h00};
    #1;
    chk("w1_rdy", 32'(bus_if.wr_req_ready), 32'h2);
    chk("w1_wa",  32'(bus_if.mem_waddr), 32'd9);

    // Both writers to addr 2: req 0 first, req 1 stays pending and wins next.
    step();
    bus_if.wr_req_valid = 2'b11;
    bus_if.wr_req_addr  = {4'd2, 4'd2};
    bus_if.wr_req_data  = {8'h22, 8'h11};
    #1;
    chk("ww0_rdy", 32'(bus_if.wr_req_ready), 32'h1);
    chk("ww0_wd",  32'(bus_if.mem_wdata), 32'h11);
    step(); bus_if.wr_req_valid = 2'b10; #1;
    chk("ww1_rdy", 32'(bus_if.wr_req_ready), 32'h2);
    chk("ww1_wa",  32'(bus_if.mem_waddr), 32'd2);
    chk("ww1_wd",  32'(bus_if.mem_wdata), 32'h22);

    // Read back addr 2 (req 0) then addr 9 (req 1).
    step();
    bus_if.wr_req_valid = 2'b00;
    bus_if.rd_req_valid = 2'b01;
    bus_if.rd_req_addr  = {4'd9, 4'd2};
    #1;
    chk("rb0_rdy", 32'(bus_if.rd_req_ready), 32'h1);
    step(); bus_if.rd_req_valid = 2'b10; #1;
    chk("rb0_rsp",  32'(bus_if.rd_rsp_valid), 32'h1);
    chk("rb0_data", 32'(bus_if.rd_rsp_data), 32'h22);
    chk("rb1_rdy",  32'(bus_if.rd_req_ready), 32'h2);
    step(); bus_if.rd_req_valid = 2'b00; #1;
    chk("rb1_rsp",  32'(bus_if.rd_rsp_valid), 32'h2);
    chk("rb1_data", 32'(bus_if.rd_rsp_data), 32'h3C);

    // init_req together with a read grant: response still arrives, then refill.
    step();
    bus_if.rd_req_valid = 2'b01;
    bus_if.rd_req_addr  = {4'd0, 4'd7};
    bus_if.init_req     = 1'b1;
    #1;
    chk("ir_rdy",  32'(bus_if.rd_req_ready), 32'h1);
    chk("ir_busy", 32'(bus_if.busy), 32'd0);
    step();
    bus_if.rd_req_valid = 2'b00;
    bus_if.init_req     = 1'b0;
    #1;
    chk("ir_rsp",  32'(bus_if.rd_rsp_valid), 32'h1);
    chk("ir_data", 32'(bus_if.rd_rsp_data), 32'hA5);
    chk_fill("init1", 0);
    for (int i = 1; i < 16; i++) begin
      step(); #1;
      chk_fill("init1", i);
      if (i == 1) chk("init1_rsp", 32'(bus_if.rd_rsp_valid), 32'h0);
    end
    step();
    bus_if.rd_req_valid = 2'b01;
    bus_if.rd_req_addr  = {4'd9, 4'd7};
    #1;
    chk("ir_done", 32'(bus_if.busy), 32'd0);
    chk("z7_rdy",  32'(bus_if.rd_req_ready), 32'h1);
    step(); bus_if.rd_req_valid = 2'b10; #1;
    chk("z7_data", 32'(bus_if.rd_rsp_data), 32'h00);
    step(); bus_if.rd_req_valid = 2'b00; #1;
    chk("z9_rsp",  32'(bus_if.rd_rsp_valid), 32'h2);
    chk("z9_data", 32'(bus_if.rd_rsp_data), 32'h00);

    // Reset hit when the fill counter reaches 9: fill restarts at 0, full length.
    step(); bus_if.init_req = 1'b1; #1;
    for (int i = 0; i < 10; i++) begin
      step(); bus_if.init_req = 1'b0; #1;
    end
    chk_fill("pre_rst", 9);
    rst = 1'b1; #1;
    chk("mid_rst_we",   32'(bus_if.mem_we), 32'd0);
    chk("mid_rst_busy", 32'(bus_if.busy), 32'd1);
    step(); rst = 1'b0; #1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin step(); #1; end
      chk_fill("init2", i);
    end
    step(); #1;
    chk("init2_done", 32'(bus_if.busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
